// File: rtl/cache_samap_line.sv
// Set-associative write-back cache with Avalon-MM core and memory ports.
// Bit 31 of the core address marks uncached accesses, which go straight to memory.
// Victim selection uses NRU, and a flush writes back every dirty line before invalidating the cache.

package cache_samap_pkg;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
  } avalon_resp_t;
endpackage

module cache_samap_line
  import cache_samap_pkg::*;
#(
  parameter int CACHE_LINE_WORDS = 4,
  parameter int CACHE_SET_DEPTH  = 32,
  parameter int CACHE_WAYS       = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  core_avn_req,
  output avalon_resp_t core_avn_resp,
  output avalon_req_t  mem_avn_req,
  input  avalon_resp_t mem_avn_resp,
  input  logic         flush_req,
  output logic         flush_busy
);
  localparam int WOFF_W = $clog2(CACHE_LINE_WORDS);
  localparam int IDX_W  = $clog2(CACHE_SET_DEPTH);
  localparam int TAG_W  = 29 - WOFF_W - IDX_W;
  localparam int WCNT_W = (WOFF_W > 0) ? WOFF_W : 1;
  localparam int ICNT_W = (IDX_W > 0) ? IDX_W : 1;
  localparam int WAY_W  = (CACHE_WAYS > 1) ? $clog2(CACHE_WAYS) : 1;

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(CACHE_LINE_WORDS - 1);
  localparam logic [ICNT_W-1:0] LAST_IDX  = ICNT_W'(CACHE_SET_DEPTH - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(CACHE_WAYS - 1);
  localparam logic [WCNT_W:0]   NUM_WORDS = (WCNT_W + 1)'(CACHE_LINE_WORDS);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WRITEBACK  = 3'd1;
  localparam logic [2:0] S_REFILL     = 3'd2;
  localparam logic [2:0] S_FLUSH_SCAN = 3'd3;
  localparam logic [2:0] S_FLUSH_WB   = 3'd4;

  function automatic logic [WCNT_W-1:0] addr_word(input logic [31:0] a);
    return WCNT_W'((a >> 2) & 32'(CACHE_LINE_WORDS - 1));
  endfunction

  function automatic logic [ICNT_W-1:0] addr_index(input logic [31:0] a);
    return ICNT_W'((a >> (2 + WOFF_W)) & 32'(CACHE_SET_DEPTH - 1));
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return TAG_W'((a & 32'h7FFF_FFFF) >> (2 + WOFF_W + IDX_W));
  endfunction

  function automatic logic [31:0] make_addr(input logic [TAG_W-1:0] t,
                                            input logic [ICNT_W-1:0] i,
                                            input logic [WCNT_W-1:0] w);
    return (32'(t) << (2 + WOFF_W + IDX_W)) | (32'(i) << (2 + WOFF_W)) | (32'(w) << 2);
  endfunction

  // Clearing the touched way's bit; when none would remain set, every other way becomes NRU.
  function automatic logic [CACHE_WAYS-1:0] nru_touch(input logic [CACHE_WAYS-1:0] cur,
                                                      input logic [WAY_W-1:0] way);
    logic [CACHE_WAYS-1:0] one_hot;
    logic [CACHE_WAYS-1:0] nxt;
    one_hot      = '0;
    one_hot[way] = 1'b1;
    nxt          = cur & ~one_hot;
    if (nxt == '0) nxt = ~one_hot;
    return nxt;
  endfunction

  logic [31:0]           data_mem [CACHE_WAYS][CACHE_SET_DEPTH][CACHE_LINE_WORDS];
  logic [TAG_W-1:0]      tag_mem  [CACHE_WAYS][CACHE_SET_DEPTH];
  logic [CACHE_WAYS-1:0] valid_q  [CACHE_SET_DEPTH];
  logic [CACHE_WAYS-1:0] dirty_q  [CACHE_SET_DEPTH];
  logic [CACHE_WAYS-1:0] nru_q    [CACHE_SET_DEPTH];

  logic [2:0]        state_q;
  logic [WCNT_W-1:0] word_cnt_q;
  logic [WCNT_W:0]   iss_cnt_q;
  logic              cap_pending_q;
  logic [WCNT_W-1:0] cap_word_q;
  logic [ICNT_W-1:0] line_idx_q;
  logic [WAY_W-1:0]  line_way_q;
  logic [TAG_W-1:0]  fill_tag_q;
  logic [ICNT_W-1:0] scan_idx_q;
  logic [WAY_W-1:0]  scan_way_q;
  logic [31:0]       rdata_q;
  logic              nc_rd_q;

  logic [WCNT_W-1:0] req_word;
  logic [ICNT_W-1:0] req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              core_access, idle, cacheable_go, nc_go, hit_accept, miss_start;
  logic              hit;
  logic [WAY_W-1:0]  hit_way, victim_way;

  assign req_word     = addr_word(core_avn_req.address);
  assign req_idx      = addr_index(core_avn_req.address);
  assign req_tag      = addr_tag(core_avn_req.address);
  assign core_access  = core_avn_req.read | core_avn_req.write;
  assign idle         = (state_q == S_IDLE);
  assign cacheable_go = idle && !flush_req && core_access && !core_avn_req.address[31];
  assign nc_go        = idle && !flush_req && core_access && core_avn_req.address[31];
  assign hit_accept   = cacheable_go && hit;
  assign miss_start   = cacheable_go && !hit;
  assign flush_busy   = (state_q == S_FLUSH_SCAN) || (state_q == S_FLUSH_WB);

  // Tag lookup and victim choice; descending loops let the lowest-numbered way win.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_way = '0;
    for (int w = CACHE_WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && tag_mem[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (nru_q[req_idx][w]) victim_way = WAY_W'(w);
    end
    for (int w = CACHE_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) victim_way = WAY_W'(w);
    end
  end

  // Core handshake: a hit answers at once, an uncached access mirrors memory, and everything else stalls.
  always_comb begin
    core_avn_resp.readdata    = nc_rd_q ? mem_avn_resp.readdata : rdata_q;
    core_avn_resp.waitrequest = 1'b0;
    if (!idle || flush_req) core_avn_resp.waitrequest = 1'b1;
    else if (nc_go)         core_avn_resp.waitrequest = mem_avn_resp.waitrequest;
    else if (cacheable_go)  core_avn_resp.waitrequest = !hit;
  end

  // Memory port: an uncached pass-through, line writeback, or refill reads, depending on state.
  always_comb begin
    mem_avn_req = '0;
    case (state_q)
      S_IDLE: if (nc_go) mem_avn_req = core_avn_req;
      S_WRITEBACK, S_FLUSH_WB: begin
        mem_avn_req.write       = 1'b1;
        mem_avn_req.address     = make_addr(tag_mem[line_way_q][line_idx_q], line_idx_q, word_cnt_q);
        mem_avn_req.writedata   = data_mem[line_way_q][line_idx_q][word_cnt_q];
        mem_avn_req.byte_enable = 4'hF;
      end
      S_REFILL: if (iss_cnt_q < NUM_WORDS) begin
        mem_avn_req.read    = 1'b1;
        mem_avn_req.address = make_addr(fill_tag_q, line_idx_q, iss_cnt_q[WCNT_W-1:0]);
      end
      default: mem_avn_req = '0;
    endcase
  end

  // Line storage: hit writes merge by byte, refill data arrives one cycle after each read is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (hit_accept && core_avn_req.read)
        rdata_q <= data_mem[hit_way][req_idx][req_word];
      if (hit_accept && core_avn_req.write)
        for (int b = 0; b < 4; b++)
          if (core_avn_req.byte_enable[b])
            data_mem[hit_way][req_idx][req_word][8*b +: 8] <= core_avn_req.writedata[8*b +: 8];
      if (state_q == S_REFILL && cap_pending_q) begin
        data_mem[line_way_q][line_idx_q][cap_word_q] <= mem_avn_resp.readdata;
        if (cap_word_q == LAST_WORD) tag_mem[line_way_q][line_idx_q] <= fill_tag_q;
      end
    end
  end

  // Controller FSM with the valid, dirty and NRU bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      word_cnt_q    <= '0;
      iss_cnt_q     <= '0;
      cap_pending_q <= 1'b0;
      cap_word_q    <= '0;
      line_idx_q    <= '0;
      line_way_q    <= '0;
      fill_tag_q    <= '0;
      scan_idx_q    <= '0;
      scan_way_q    <= '0;
      nc_rd_q       <= 1'b0;
      for (int d = 0; d < CACHE_SET_DEPTH; d++) begin
        valid_q[d] <= '0;
        dirty_q[d] <= '0;
        nru_q[d]   <= '1;
      end
    end else begin
      nc_rd_q <= nc_go && core_avn_req.read && !mem_avn_resp.waitrequest;
      case (state_q)
        S_IDLE: begin
          if (flush_req) begin
            scan_idx_q <= '0;
            scan_way_q <= '0;
            state_q    <= S_FLUSH_SCAN;
          end else if (hit_accept) begin
            nru_q[req_idx] <= nru_touch(nru_q[req_idx], hit_way);
            if (core_avn_req.write) dirty_q[req_idx][hit_way] <= 1'b1;
          end else if (miss_start) begin
            line_idx_q    <= req_idx;
            line_way_q    <= victim_way;
            fill_tag_q    <= req_tag;
            word_cnt_q    <= '0;
            iss_cnt_q     <= '0;
            cap_pending_q <= 1'b0;
            state_q <= (valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way])
                       ? S_WRITEBACK : S_REFILL;
          end
        end
        S_WRITEBACK: begin
          if (!mem_avn_resp.waitrequest) begin
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_q <= '0;
              state_q    <= S_REFILL;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        S_REFILL: begin
          if (mem_avn_req.read && !mem_avn_resp.waitrequest) iss_cnt_q <= iss_cnt_q + 1'b1;
          cap_pending_q <= mem_avn_req.read && !mem_avn_resp.waitrequest;
          cap_word_q    <= iss_cnt_q[WCNT_W-1:0];
          if (cap_pending_q && cap_word_q == LAST_WORD) begin
            valid_q[line_idx_q][line_way_q] <= 1'b1;
            dirty_q[line_idx_q][line_way_q] <= 1'b0;
            nru_q[line_idx_q] <= nru_touch(nru_q[line_idx_q], line_way_q);
            state_q <= S_IDLE;
          end
        end
        S_FLUSH_SCAN: begin
          if (valid_q[scan_idx_q][scan_way_q] && dirty_q[scan_idx_q][scan_way_q]) begin
            line_idx_q <= scan_idx_q;
            line_way_q <= scan_way_q;
            word_cnt_q <= '0;
            state_q    <= S_FLUSH_WB;
          end else if (scan_idx_q == LAST_IDX && scan_way_q == LAST_WAY) begin
            for (int d = 0; d < CACHE_SET_DEPTH; d++) begin
              valid_q[d] <= '0;
              dirty_q[d] <= '0;
              nru_q[d]   <= '1;
            end
            state_q <= S_IDLE;
          end else if (scan_way_q == LAST_WAY) begin
            scan_way_q <= '0;
            scan_idx_q <= scan_idx_q + 1'b1;
          end else begin
            scan_way_q <= scan_way_q + 1'b1;
          end
        end
        S_FLUSH_WB: begin
          if (!mem_avn_resp.waitrequest) begin
            if (word_cnt_q == LAST_WORD) begin
              dirty_q[line_idx_q][line_way_q] <= 1'b0;
              word_cnt_q <= '0;
              state_q    <= S_FLUSH_SCAN;
            end else begin
              word_cnt_q <= word_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_samap_line.sv
// Directed bench for cache_samap_line (2 ways, 4 words per line, 16 sets).
// A behavioural Avalon memory logs every accepted transaction and can stall one chosen address.

module tb_cache_samap_line;
  import cache_samap_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  avalon_req_t  core_req;
  avalon_resp_t core_resp;
  avalon_req_t  mem_req;
  avalon_resp_t mem_resp;
  logic         flush_req;
  logic         flush_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_samap_line #(
    .CACHE_LINE_WORDS(4),
    .CACHE_SET_DEPTH (16),
    .CACHE_WAYS      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .core_avn_req (core_req),
    .core_avn_resp(core_resp),
    .mem_avn_req  (mem_req),
    .mem_avn_resp (mem_resp),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy)
  );

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        txn_log   [$];
  txn_t        stall_log [$];
  logic [31:0] mem_words   [1024];
  bit          mem_written [1024];
  logic [31:0] mem_rdata_q = '0;
  int          stall_used = 0;
  int          stall_base;
  int          stall_len;
  logic [31:0] stall_addr;

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return 32'hA500_0000 | {20'h0, a[11:2], 2'b00};
  endfunction

  // Memory stalls the chosen address for stall_len cycles counted from stall_base.
  always_comb begin
    mem_resp.readdata    = mem_rdata_q;
    mem_resp.waitrequest = (mem_req.read || mem_req.write) && (mem_req.address == stall_addr)
                           && ((stall_used - stall_base) < stall_len);
  end

  // Memory model: log accepted and stalled transfers, return read data one cycle later.
  always @(posedge clk) begin
    logic [31:0] merged;
    if ((mem_req.read || mem_req.write) && mem_resp.waitrequest) begin
      stall_used <= stall_used + 1;
      stall_log.push_back('{mem_req.write, mem_req.address, mem_req.writedata});
    end
    if (mem_req.read && !mem_resp.waitrequest) begin
      mem_rdata_q <= mem_written[mem_req.address[11:2]] ? mem_words[mem_req.address[11:2]]
                                                         : default_word(mem_req.address);
      txn_log.push_back('{1'b0, mem_req.address, 32'h0});
    end
    if (mem_req.write && !mem_resp.waitrequest) begin
      merged = mem_written[mem_req.address[11:2]] ? mem_words[mem_req.address[11:2]]
                                                   : default_word(mem_req.address);
      for (int b = 0; b < 4; b++)
        if (mem_req.byte_enable[b]) merged[8*b +: 8] = mem_req.writedata[8*b +: 8];
      mem_words[mem_req.address[11:2]]   <= merged;
      mem_written[mem_req.address[11:2]] <= 1'b1;
      txn_log.push_back('{1'b1, mem_req.address, mem_req.writedata});
    end
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_txn(input string tag, input int pos, input bit is_write,
                           input logic [31:0] addr);
    logic [31:0] obs_addr;
    logic [31:0] obs_kind;
    obs_addr = 'x;
    obs_kind = 'x;
    if (pos < txn_log.size()) begin
      obs_addr = txn_log[pos].addr;
      obs_kind = {31'd0, txn_log[pos].is_write};
    end
    check_output({tag, "_addr"}, obs_addr, addr);
    check_output({tag, "_kind"}, obs_kind, {31'd0, is_write});
  endtask

  task automatic check_wdata(input string tag, input int pos, input logic [31:0] data);
    logic [31:0] obs;
    obs = 'x;
    if (pos < txn_log.size()) obs = txn_log[pos].data;
    check_output(tag, obs, data);
  endtask

  // One core transfer: hold the request until accepted, then sample readdata a cycle later.
  task automatic apply_stimulus(input bit is_write, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                output logic [31:0] rdata, output int waits);
    bit accepted;
    @(negedge clk);
    core_req.read        = !is_write;
    core_req.write       = is_write;
    core_req.address     = addr;
    core_req.writedata   = wdata;
    core_req.byte_enable = be;
    waits    = 0;
    accepted = 0;
    while (!accepted && waits < 300) begin
      #1;
      accepted = !core_resp.waitrequest;
      @(posedge clk);
      if (!accepted) begin
        waits++;
        @(negedge clk);
      end
    end
    check_output("core_accepted", {31'd0, accepted}, 32'd1);
    @(negedge clk);
    rdata    = core_resp.readdata;
    core_req = '0;
  endtask

  initial begin
    logic [31:0] rd;
    int          waits;
    int          base;
    int          sbase;
    int          guard;
    logic [31:0] wb_data [4];

    core_req   = '0;
    flush_req  = 1'b0;
    rst        = 1'b1;
    stall_len  = 0;
    stall_base = 0;
    stall_addr = '0;
    repeat (3) @(negedge clk);
    #1;
    check_output("reset_core_wait", {31'd0, core_resp.waitrequest}, 32'd0);
    check_output("reset_mem_read",  {31'd0, mem_req.read}, 32'd0);
    check_output("reset_mem_write", {31'd0, mem_req.write}, 32'd0);
    check_output("reset_flush_busy", {31'd0, flush_busy}, 32'd0);
    rst = 1'b0;

    $display("[TB] cold read 0x40 and hit on 0x44");
    base = txn_log.size();
    apply_stimulus(1'b0, 32'h40, 32'h0, 4'h0, rd, waits);
    check_output("cold_read_data", rd, 32'hA500_0040);
    check_output("cold_read_count", 32'(txn_log.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) check_txn("cold_refill", base + k, 1'b0, 32'h40 + 32'(4 * k));
    base = txn_log.size();
    apply_stimulus(1'b0, 32'h44, 32'h0, 4'h0, rd, waits);
    check_output("hit_read_data", rd, 32'hA500_0044);
    check_output("hit_read_waits", 32'(waits), 32'd0);
    check_output("hit_read_count", 32'(txn_log.size() - base), 32'd0);

    $display("[TB] dirty eviction with stalled third writeback word");
    base = txn_log.size();
    apply_stimulus(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, rd, waits);
    check_output("hit_write_waits", 32'(waits), 32'd0);
    check_output("hit_write_count", 32'(txn_log.size() - base), 32'd0);
    base = txn_log.size();
    apply_stimulus(1'b0, 32'h140, 32'h0, 4'h0, rd, waits);
    check_output("way1_fill_data", rd, 32'hA500_0140);
    check_output("way1_fill_count", 32'(txn_log.size() - base), 32'd4);
    check_txn("way1_fill_first", base, 1'b0, 32'h140);
    stall_base = stall_used;
    stall_addr = 32'h48;
    stall_len  = 2;
    sbase = stall_log.size();
    base  = txn_log.size();
    apply_stimulus(1'b0, 32'h240, 32'h0, 4'h0, rd, waits);
    stall_len = 0;
    wb_data = '{32'hDEAD_BEEF, 32'hA500_0044, 32'hA500_0048, 32'hA500_004C};
    check_output("evict_read_data", rd, 32'hA500_0240);
    check_output("evict_count", 32'(txn_log.size() - base), 32'd8);
    for (int k = 0; k < 4; k++) begin
      check_txn("evict_wb", base + k, 1'b1, 32'h40 + 32'(4 * k));
      check_wdata("evict_wb_data", base + k, wb_data[k]);
      check_txn("evict_refill", base + 4 + k, 1'b0, 32'h240 + 32'(4 * k));
    end
    check_output("stall_cycles", 32'(stall_log.size() - sbase), 32'd2);
    for (int k = 0; k < 2; k++) begin
      check_output("stall_hold_addr",
                   (sbase + k < stall_log.size()) ? stall_log[sbase + k].addr : 32'hx, 32'h48);
      check_output("stall_hold_data",
                   (sbase + k < stall_log.size()) ? stall_log[sbase + k].data : 32'hx, 32'hA500_0048);
    end

    $display("[TB] uncached read with three stall cycles");
    stall_base = stall_used;
    stall_addr = 32'h8000_0010;
    stall_len  = 3;
    base = txn_log.size();
    apply_stimulus(1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, waits);
    stall_len = 0;
    check_output("nc_read_data", rd, 32'hA500_0010);
    check_output("nc_read_waits", 32'(waits), 32'd3);
    check_output("nc_read_count", 32'(txn_log.size() - base), 32'd1);
    check_txn("nc_read", base, 1'b0, 32'h8000_0010);
    base = txn_log.size();
    apply_stimulus(1'b0, 32'h240, 32'h0, 4'h0, rd, waits);
    check_output("post_nc_hit_data", rd, 32'hA500_0240);
    check_output("post_nc_hit_waits", 32'(waits), 32'd0);
    check_output("post_nc_hit_count", 32'(txn_log.size() - base), 32'd0);

    $display("[TB] write-allocate with partial byte enable, then flush");
    base = txn_log.size();
    apply_stimulus(1'b1, 32'h40, 32'h1234_5678, 4'b0011, rd, waits);
    check_output("wmiss_count", 32'(txn_log.size() - base), 32'd4);
    check_txn("wmiss_refill_first", base, 1'b0, 32'h40);
    apply_stimulus(1'b0, 32'h40, 32'h0, 4'h0, rd, waits);
    check_output("merged_data", rd, 32'hDEAD_5678);
    check_output("merged_waits", 32'(waits), 32'd0);

    base = txn_log.size();
    @(negedge clk);
    flush_req        = 1'b1;
    core_req.read    = 1'b1;
    core_req.address = 32'h240;
    #1;
    check_output("flush_beats_core", {31'd0, core_resp.waitrequest}, 32'd1);
    @(negedge clk);
    flush_req = 1'b0;
    core_req  = '0;
    #1;
    check_output("flush_busy_rise", {31'd0, flush_busy}, 32'd1);
    guard = 0;
    while (flush_busy && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_output("flush_done", {31'd0, flush_busy}, 32'd0);
    check_output("flush_count", 32'(txn_log.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) check_txn("flush_wb", base + k, 1'b1, 32'h40 + 32'(4 * k));
    check_wdata("flush_wb_first_data", base, 32'hDEAD_5678);
    base = txn_log.size();
    apply_stimulus(1'b0, 32'h40, 32'h0, 4'h0, rd, waits);
    check_output("post_flush_data", rd, 32'hDEAD_5678);
    check_output("post_flush_count", 32'(txn_log.size() - base), 32'd4);
    check_txn("post_flush_refill", base, 1'b0, 32'h40);

    $display("[TB] reset during refill of 0x300");
    base = txn_log.size();
    @(negedge clk);
    core_req.read    = 1'b1;
    core_req.address = 32'h300;
    guard = 0;
    while ((txn_log.size() - base) < 2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_output("rst_two_reads", 32'(txn_log.size() - base), 32'd2);
    check_output("rst_read_active", {31'd0, mem_req.read}, 32'd1);
    rst      = 1'b1;
    core_req = '0;
    @(negedge clk);
    #1;
    check_output("rst_read_drop", {31'd0, mem_req.read}, 32'd0);
    check_output("rst_write_low", {31'd0, mem_req.write}, 32'd0);
    rst  = 1'b0;
    base = txn_log.size();
    apply_stimulus(1'b0, 32'h300, 32'h0, 4'h0, rd, waits);
    check_output("rst_reread_data", rd, 32'hA500_0300);
    check_output("rst_reread_count", 32'(txn_log.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) check_txn("rst_refill", base + k, 1'b0, 32'h300 + 32'(4 * k));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
